nano4k_spi_flash_responder: RTL and testbench

- Synthesizable SPI NOR flash responder: the device end of the flash bus our SPI flash master drives (P25Q32H command subset, CPOL=1 mode 3, single-bit I/O).
- Oversamples MCLK/CS_n/MOSI on one fast clock, decodes commands, and serves reads/programs from an external synchronous memory port (BSRAM).
- Used as an on-FPGA loopback target for master bring-up and regression, and as a flash emulator.

---
 rtl/nano4k_spi_flash_pkg.sv | 36 +++
 rtl/nano4k_spi_flash_responder_sync_edge.sv | 35 +++
 rtl/nano4k_spi_flash_responder.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_nano4k_spi_flash_responder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/nano4k_spi_flash_pkg.sv
// Shared definitions for the nano4k SPI flash responder and its master:
// opcodes, responder FSM encoding and status register layout.
package nano4k_spi_flash_pkg;

    localparam logic [7:0] OP_FREAD = 8'h0B;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_RSTEN = 8'h66;
    localparam logic [7:0] OP_RST   = 8'h99;
    localparam logic [7:0] OP_PP    = 8'h02;
    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_RDCR  = 8'h35;
    localparam logic [7:0] OP_RDID  = 8'h9F;

    localparam int SR_WIP = 0;
    localparam int SR_WEL = 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_ADDR    = 3'd2,
        ST_DUMMY   = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_WR_DATA = 3'd5,
        ST_IGNORE  = 3'd6
    } state_t;

    function automatic logic [7:0] status_byte(input logic wel, input logic wip);
        logic [7:0] s;
        s         = 8'h00;
        s[SR_WEL] = wel;
        s[SR_WIP] = wip;
        return s;
    endfunction

endpackage

// File: rtl/nano4k_spi_flash_responder_sync_edge.sv
// Two-flop synchroniser for one asynchronous SPI pin, with rise/fall
// detection on the synchronised copy.
module spi_resp_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchroniser chain plus one delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
            r_prev <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/nano4k_spi_flash_responder.sv
// SPI NOR flash responder (mode 3, single-bit I/O) backed by an external
// synchronous byte memory; oversamples the bus on interfaceClk.
module nano4k_spi_flash_responder
    import nano4k_spi_flash_pkg::*;
#(
    parameter int          ADDR_W           = 22,
    parameter logic [23:0] JEDEC_ID         = 24'h856016,
    parameter int          PROG_BUSY_CYCLES = 64,
    parameter int          DUMMY_BYTES      = 1
) (
    input  logic              interfaceClk,
    input  logic              reset_n,
    input  logic              MCLK,
    input  logic              CS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic              MISO_oe,
    output logic [ADDR_W-1:0] memAddr,
    output logic              memRdEn,
    input  logic [7:0]        memRdData,
    output logic              memWrEn,
    output logic [7:0]        memWrData
);

    localparam int                BUSY_W     = $clog2(PROG_BUSY_CYCLES + 1);
    localparam logic [BUSY_W-1:0] BUSY_LOAD  = BUSY_W'(PROG_BUSY_CYCLES);
    localparam logic [7:0]        DUMMY_LAST = 8'(DUMMY_BYTES * 8 - 1);

    logic w_mclk_lvl_unused, w_mclk_rise, w_mclk_fall;
    logic w_cs, w_cs_rise, w_cs_fall;
    logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;

    spi_resp_sync_edge #(.RESET_VAL(1'b1)) u_sync_mclk (
        .clk(interfaceClk), .rst_n(reset_n), .i_async(MCLK),
        .o_sync(w_mclk_lvl_unused), .o_rise(w_mclk_rise), .o_fall(w_mclk_fall));
    spi_resp_sync_edge #(.RESET_VAL(1'b1)) u_sync_cs (
        .clk(interfaceClk), .rst_n(reset_n), .i_async(CS_n),
        .o_sync(w_cs), .o_rise(w_cs_rise), .o_fall(w_cs_fall));
    spi_resp_sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
        .clk(interfaceClk), .rst_n(reset_n), .i_async(MOSI),
        .o_sync(w_mosi), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused));

    state_t              r_state, w_state_next;
    logic [7:0]          r_bit_cnt;
    logic [6:0]          r_shift_in;
    logic [7:0]          r_opcode;
    logic [ADDR_W-2:0]   r_addr_sh;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [7:0]          r_page_off;
    logic                r_mem_rd_en, r_mem_wr_en, r_cap;
    logic [7:0]          r_mem_wr_data;
    logic [7:0]          r_next_byte, r_shift_out;
    logic [2:0]          r_out_cnt;
    logic [1:0]          r_rd_idx;
    logic                r_miso, r_miso_oe;
    logic                r_cmd_done, r_wrote;
    logic                r_wel, r_wip, r_rst_armed;
    logic [BUSY_W-1:0]   r_busy_cnt;
    logic [7:0]          w_byte_in, w_id_byte;
    logic [ADDR_W-1:0]   w_addr_mem;
    logic                w_enter_rd, w_is_mem_rd;

    assign w_byte_in   = {r_shift_in, w_mosi};
    assign w_addr_mem  = {r_addr_sh, w_mosi};
    assign w_enter_rd  = (w_state_next == ST_RD_DATA) && (r_state != ST_RD_DATA);
    assign w_is_mem_rd = (r_opcode == OP_READ) || (r_opcode == OP_FREAD);

    // RDID byte selected by the rotating 0..2 index.
    always_comb begin
        w_id_byte = JEDEC_ID[23:16];
        case (r_rd_idx)
            2'd0:    w_id_byte = JEDEC_ID[23:16];
            2'd1:    w_id_byte = JEDEC_ID[15:8];
            2'd2:    w_id_byte = JEDEC_ID[7:0];
            default: w_id_byte = JEDEC_ID[23:16];
        endcase
    end

    // FSM state register.
    always_ff @(posedge interfaceClk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; a high chip select overrides everything.
    always_comb begin
        w_state_next = r_state;
        if (w_cs) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall) w_state_next = ST_CMD;
                    else           w_state_next = ST_IDLE;
                end
                ST_CMD: begin
                    if (w_mclk_rise && (r_bit_cnt == 8'd7)) begin
                        case (w_byte_in)
                            OP_READ, OP_FREAD, OP_PP: w_state_next = ST_ADDR;
                            OP_RDSR, OP_RDCR, OP_RDID: w_state_next = ST_RD_DATA;
                            default:                 w_state_next = ST_IGNORE;
                        endcase
                    end else begin
                        w_state_next = ST_CMD;
                    end
                end
                ST_ADDR: begin
                    if (w_mclk_rise && (r_bit_cnt == 8'd23)) begin
                        case (r_opcode)
                            OP_FREAD: w_state_next = ST_DUMMY;
                            OP_READ:  w_state_next = ST_RD_DATA;
                            OP_PP:    w_state_next = (r_wel && !r_wip) ? ST_WR_DATA : ST_IGNORE;
                            default:  w_state_next = ST_IGNORE;
                        endcase
                    end else begin
                        w_state_next = ST_ADDR;
                    end
                end
                ST_DUMMY: begin
                    if (w_mclk_rise && (r_bit_cnt == DUMMY_LAST)) w_state_next = ST_RD_DATA;
                    else                                          w_state_next = ST_DUMMY;
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    // Bus datapath, memory port, status register and busy timer.
    always_ff @(posedge interfaceClk or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_cnt     <= 8'd0;
            r_shift_in    <= 7'd0;
            r_opcode      <= 8'h00;
            r_addr_sh     <= '0;
            r_mem_addr    <= '0;
            r_page_off    <= 8'd0;
            r_mem_rd_en   <= 1'b0;
            r_mem_wr_en   <= 1'b0;
            r_mem_wr_data <= 8'h00;
            r_cap         <= 1'b0;
            r_next_byte   <= 8'h00;
            r_shift_out   <= 8'h00;
            r_out_cnt     <= 3'd0;
            r_rd_idx      <= 2'd0;
            r_miso        <= 1'b0;
            r_miso_oe     <= 1'b0;
            r_cmd_done    <= 1'b0;
            r_wrote       <= 1'b0;
            r_wel         <= 1'b0;
            r_wip         <= 1'b0;
            r_rst_armed   <= 1'b0;
            r_busy_cnt    <= '0;
        end else begin
            r_mem_rd_en <= 1'b0;
            r_mem_wr_en <= 1'b0;
            r_cap       <= r_mem_rd_en;

            // Memory (or register) data arrives one cycle after the read strobe.
            if (r_cap) begin
                case (r_opcode)
                    OP_READ, OP_FREAD: r_next_byte <= memRdData;
                    OP_RDSR:           r_next_byte <= status_byte(r_wel, r_wip);
                    OP_RDID:           r_next_byte <= w_id_byte;
                    default:           r_next_byte <= 8'h00;
                endcase
            end

            if (r_wip) begin
                if (r_busy_cnt == '0) r_wip      <= 1'b0;
                else                  r_busy_cnt <= r_busy_cnt - BUSY_W'(1);
            end

            if (w_cs_fall) begin
                r_cmd_done <= 1'b0;
                r_wrote    <= 1'b0;
            end

            if (w_cs) begin
                r_bit_cnt <= 8'd0;
                r_miso    <= 1'b0;
                r_miso_oe <= 1'b0;
            end else if (w_mclk_rise) begin
                case (r_state)
                    ST_CMD: begin
                        r_shift_in <= w_byte_in[6:0];
                        if (r_bit_cnt == 8'd7) begin
                            r_opcode   <= w_byte_in;
                            r_cmd_done <= 1'b1;
                            r_bit_cnt  <= 8'd0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 8'd1;
                        end
                    end
                    ST_ADDR: begin
                        r_addr_sh <= w_addr_mem[ADDR_W-2:0];
                        if (r_bit_cnt == 8'd23) begin
                            r_mem_addr <= w_addr_mem;
                            r_page_off <= w_addr_mem[7:0];
                            r_bit_cnt  <= 8'd0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 8'd1;
                        end
                    end
                    ST_DUMMY: begin
                        if (r_bit_cnt == DUMMY_LAST) r_bit_cnt <= 8'd0;
                        else                         r_bit_cnt <= r_bit_cnt + 8'd1;
                    end
                    ST_WR_DATA: begin
                        r_shift_in <= w_byte_in[6:0];
                        if (r_bit_cnt == 8'd7) begin
                            r_mem_wr_en   <= 1'b1;
                            r_mem_wr_data <= w_byte_in;
                            r_mem_addr    <= {r_mem_addr[ADDR_W-1:8], r_page_off};
                            r_page_off    <= r_page_off + 8'd1;
                            r_wrote       <= 1'b1;
                            r_bit_cnt     <= 8'd0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 8'd1;
                        end
                    end
                    default: r_bit_cnt <= r_bit_cnt;
                endcase
            end else if (w_mclk_fall && (r_state == ST_RD_DATA)) begin
                // First bit of each byte comes from the prefetch buffer, which is then refilled.
                if (r_out_cnt == 3'd0) begin
                    r_miso      <= r_next_byte[7];
                    r_shift_out <= {r_next_byte[6:0], 1'b0};
                    r_mem_rd_en <= 1'b1;
                    r_rd_idx    <= (r_rd_idx == 2'd2) ? 2'd0 : r_rd_idx + 2'd1;
                    if (w_is_mem_rd) r_mem_addr <= r_mem_addr + ADDR_W'(1);
                end else begin
                    r_miso      <= r_shift_out[7];
                    r_shift_out <= {r_shift_out[6:0], 1'b0};
                end
                r_out_cnt <= r_out_cnt + 3'd1;
            end

            if (w_enter_rd) begin
                r_mem_rd_en <= 1'b1;
                r_rd_idx    <= 2'd0;
                r_out_cnt   <= 3'd0;
                r_miso_oe   <= 1'b1;
            end

            if (w_cs_rise && r_cmd_done) begin
                r_cmd_done <= 1'b0;
                case (r_opcode)
                    OP_WREN: begin
                        r_wel       <= 1'b1;
                        r_rst_armed <= 1'b0;
                    end
                    OP_RSTEN: r_rst_armed <= 1'b1;
                    OP_RST: begin
                        if (r_rst_armed) begin
                            r_wel      <= 1'b0;
                            r_wip      <= 1'b0;
                            r_busy_cnt <= '0;
                        end
                        r_rst_armed <= 1'b0;
                    end
                    OP_PP: begin
                        if (r_wrote) begin
                            r_wel      <= 1'b0;
                            r_wip      <= 1'b1;
                            r_busy_cnt <= BUSY_LOAD;
                        end
                        r_rst_armed <= 1'b0;
                    end
                    default: r_rst_armed <= 1'b0;
                endcase
            end
        end
    end

    assign MISO      = r_miso;
    assign MISO_oe   = r_miso_oe;
    assign memAddr   = r_mem_addr;
    assign memRdEn   = r_mem_rd_en;
    assign memWrEn   = r_mem_wr_en;
    assign memWrData = r_mem_wr_data;

endmodule

// File: tb/tb_nano4k_spi_flash_responder.sv
// Bench for the SPI flash responder: a bit-banged mode-3 master, a byte
// memory model and a queue of expected MISO bytes.
module tb_nano4k_spi_flash_responder;
    import nano4k_spi_flash_pkg::*;

    localparam int ADDR_W = 22;
    localparam int BUSY   = 300;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              MCLK, CS_n, MOSI;
    logic              MISO, MISO_oe;
    logic [ADDR_W-1:0] memAddr;
    logic              memRdEn, memWrEn;
    logic [7:0]        memRdData, memWrData;

    always #5 clk = ~clk;

    nano4k_spi_flash_responder #(
        .ADDR_W(ADDR_W), .JEDEC_ID(24'h856016),
        .PROG_BUSY_CYCLES(BUSY), .DUMMY_BYTES(1)
    ) dut (
        .interfaceClk(clk), .reset_n(reset_n), .MCLK(MCLK), .CS_n(CS_n),
        .MOSI(MOSI), .MISO(MISO), .MISO_oe(MISO_oe), .memAddr(memAddr),
        .memRdEn(memRdEn), .memRdData(memRdData), .memWrEn(memWrEn),
        .memWrData(memWrData)
    );

    logic [7:0]        mem [int];
    logic [ADDR_W-1:0] rd_log [$];
    logic [29:0]       wr_log [$];
    logic [7:0]        exp_q [$];
    int                checks = 0;
    int                errors = 0;

    // Synchronous byte memory with logs of every strobe.
    always @(posedge clk) begin
        if (memWrEn) begin
            mem[int'(memAddr)] = memWrData;
            wr_log.push_back({memAddr, memWrData});
        end
        if (memRdEn) begin
            rd_log.push_back(memAddr);
            if (mem.exists(int'(memAddr))) memRdData <= mem[int'(memAddr)];
            else                           memRdData <= 8'h00;
        end
    end

    typedef struct {
        string       name;
        int          ntx;
        logic [47:0] tx;
        int          nrx;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx, output logic oe_seen);
        oe_seen = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            MCLK = 1'b0;
            MOSI = tx[i];
            wait_clk(4);
            rx[i] = MISO;
            if (i == 7) oe_seen = MISO_oe;
            MCLK = 1'b1;
            wait_clk(4);
        end
    endtask

    task automatic cs_lo();
        CS_n = 1'b0;
        wait_clk(4);
    endtask

    task automatic cs_hi();
        wait_clk(4);
        CS_n = 1'b1;
        wait_clk(8);
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0] rx, e;
        logic       oe;
        cs_lo();
        for (int k = 0; k < v.ntx; k++) spi_byte(v.tx[47-8*k -: 8], rx, oe);
        for (int k = 0; k < v.nrx; k++) exp_q.push_back(v.exp[31-8*k -: 8]);
        for (int k = 0; k < v.nrx; k++) begin
            spi_byte(8'h00, rx, oe);
            e = exp_q.pop_front();
            check({v.name, " data"}, 64'(rx), 64'(e));
            check({v.name, " oe"}, 64'(oe), 64'd1);
        end
        cs_hi();
        if (v.nrx > 0) check({v.name, " oe after CS rise"}, 64'(MISO_oe), 64'd0);
    endtask

    initial begin
        logic [7:0] rx;
        logic       oe, got_zero;

        vecs[0]  = '{"RDID",       1, 48'h9F0000000000, 4, 32'h85601685};
        vecs[1]  = '{"READ",       4, 48'h030012340000, 2, 32'hA55A0000};
        vecs[2]  = '{"FREAD",      5, 48'h0B3FFFFF0000, 2, 32'hC33C0000};
        vecs[3]  = '{"RDCR",       1, 48'h350000000000, 1, 32'h00000000};
        vecs[4]  = '{"PP no WEL",  5, 48'h020000107700, 0, 32'h00000000};
        vecs[5]  = '{"RDSR idle",  1, 48'h050000000000, 1, 32'h00000000};
        vecs[6]  = '{"WREN",       1, 48'h060000000000, 0, 32'h00000000};
        vecs[7]  = '{"RDSR WEL",   1, 48'h050000000000, 1, 32'h02000000};
        vecs[8]  = '{"PP wrap",    6, 48'h020000FF1122, 0, 32'h00000000};
        vecs[9]  = '{"WREN",       1, 48'h060000000000, 0, 32'h00000000};
        vecs[10] = '{"RSTEN",      1, 48'h660000000000, 0, 32'h00000000};
        vecs[11] = '{"RST",        1, 48'h990000000000, 0, 32'h00000000};
        vecs[12] = '{"RDSR rst",   1, 48'h050000000000, 1, 32'h00000000};
        vecs[13] = '{"WREN",       1, 48'h060000000000, 0, 32'h00000000};
        vecs[14] = '{"RST alone",  1, 48'h990000000000, 0, 32'h00000000};
        vecs[15] = '{"RDSR kept",  1, 48'h050000000000, 1, 32'h02000000};
        vecs[16] = '{"RDSR areset",1, 48'h050000000000, 1, 32'h00000000};

        mem[32'h001234] = 8'hA5;
        mem[32'h001235] = 8'h5A;
        mem[32'h3FFFFF] = 8'hC3;
        mem[32'h000000] = 8'h3C;

        MCLK = 1'b1; CS_n = 1'b1; MOSI = 1'b0; reset_n = 1'b0;
        wait_clk(3);
        check("reset outputs", 64'({MISO, MISO_oe, memRdEn, memWrEn, memWrData, memAddr}), 64'd0);
        reset_n = 1'b1;
        wait_clk(4);

        run_vec(vecs[0]);
        rd_log.delete();
        run_vec(vecs[1]);
        check("READ rd count", 64'(rd_log.size()), 64'd3);
        for (int k = 0; k < 3; k++)
            if (k < rd_log.size()) check("READ rd addr", 64'(rd_log[k]), 64'(22'h001234 + k));
        rd_log.delete();
        run_vec(vecs[2]);
        check("FREAD rd count", 64'(rd_log.size()), 64'd3);
        if (rd_log.size() >= 2) begin
            check("FREAD rd addr0", 64'(rd_log[0]), 64'h3FFFFF);
            check("FREAD rd addr1", 64'(rd_log[1]), 64'h000000);
        end
        run_vec(vecs[3]);

        wr_log.delete();
        run_vec(vecs[4]);
        check("PP no WEL writes", 64'(wr_log.size()), 64'd0);
        for (int i = 5; i < 8; i++) run_vec(vecs[i]);
        wr_log.delete();
        run_vec(vecs[8]);
        check("PP write count", 64'(wr_log.size()), 64'd2);
        if (wr_log.size() >= 2) begin
            check("PP write0", 64'(wr_log[0]), 64'({22'h0000FF, 8'h11}));
            check("PP write1", 64'(wr_log[1]), 64'({22'h000000, 8'h22}));
        end

        // Poll status within one RDSR until the busy timer expires.
        cs_lo();
        spi_byte(OP_RDSR, rx, oe);
        spi_byte(8'h00, rx, oe);
        check("RDSR after PP", 64'(rx), 64'h01);
        got_zero = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (!got_zero) begin
                spi_byte(8'h00, rx, oe);
                if (rx == 8'h00) got_zero = 1'b1;
            end
        end
        cs_hi();
        check("WIP clears", 64'(got_zero), 64'd1);

        for (int i = 9; i < 16; i++) run_vec(vecs[i]);

        // Asynchronous reset in the middle of a READ data byte.
        run_vec(vecs[6]);
        cs_lo();
        spi_byte(OP_READ, rx, oe);
        spi_byte(8'h00, rx, oe);
        spi_byte(8'h12, rx, oe);
        spi_byte(8'h34, rx, oe);
        for (int i = 0; i < 3; i++) begin
            MCLK = 1'b0; wait_clk(4);
            MCLK = 1'b1; wait_clk(4);
        end
        MCLK = 1'b0;
        wait_clk(3);
        check("mid-READ oe before reset", 64'(MISO_oe), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset outputs", 64'({MISO, MISO_oe, memRdEn, memWrEn, memWrData, memAddr}), 64'd0);
        wait_clk(3);
        reset_n = 1'b1;
        MCLK = 1'b1;
        cs_hi();
        run_vec(vecs[16]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
